// File: rtl/execute_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the execute stage.
package execute_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;
    localparam logic [3:0] OP_PASSB = 4'd14;
    localparam logic [3:0] OP_NOP   = 4'd15;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    function automatic logic is_multi_cycle(input logic [3:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

endpackage

// File: rtl/execute_if.sv
// ID/EX-side inputs and EX/MEM-side outputs of the execute stage.
interface execute_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 6
);
    logic                      in_valid;
    logic [DATA_WIDTH-1:0]     op_a;
    logic [DATA_WIDTH-1:0]     op_b;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_in;
    logic [3:0]                ex_ctrl_in;
    logic [2:0]                mem_ctrl_in;
    logic [1:0]                wb_ctrl_in;
    logic                      flush;
    logic                      stall_out;
    logic                      out_valid;
    logic [DATA_WIDTH-1:0]     result_out;
    logic                      zero_out;
    logic [DATA_WIDTH-1:0]     store_data_out;
    logic [REG_ADDR_WIDTH-1:0] reg_addr_out;
    logic [2:0]                mem_ctrl_out;
    logic [1:0]                wb_ctrl_out;

    modport master (
        output in_valid, op_a, op_b, reg_addr_in, ex_ctrl_in, mem_ctrl_in, wb_ctrl_in, flush,
        input  stall_out, out_valid, result_out, zero_out, store_data_out,
               reg_addr_out, mem_ctrl_out, wb_ctrl_out
    );

    modport slave (
        input  in_valid, op_a, op_b, reg_addr_in, ex_ctrl_in, mem_ctrl_in, wb_ctrl_in, flush,
        output stall_out, out_valid, result_out, zero_out, store_data_out,
               reg_addr_out, mem_ctrl_out, wb_ctrl_out
    );
endinterface

// File: rtl/execute_muldiv_unit.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one step per cycle.
// o_result is the value the current step produces, so it is valid at the edge where o_last is high.
module execute_muldiv_unit
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [3:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_last,
    output logic [DATA_WIDTH-1:0] o_result
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    logic                  r_active;
    logic [CW-1:0]         r_count;
    logic                  r_is_div;
    logic                  r_sel_lo;
    // r_hi: upper product half / partial remainder; r_lo: multiplier bits / dividend-to-quotient
    logic [DATA_WIDTH-1:0] r_hi;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_opnd;

    logic [DATA_WIDTH:0]   w_mul_sum;
    logic [DATA_WIDTH:0]   w_div_shift;
    logic [DATA_WIDTH:0]   w_div_trial;
    logic [DATA_WIDTH-1:0] w_hi_nxt;
    logic [DATA_WIDTH-1:0] w_lo_nxt;

    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_hi, r_lo[DATA_WIDTH-1]};
        w_div_trial = w_div_shift - {1'b0, r_opnd};
        if (r_is_div) begin
            // A borrow out of the trial subtraction restores the shifted remainder
            w_hi_nxt = w_div_trial[DATA_WIDTH] ? w_div_shift[DATA_WIDTH-1:0]
                                               : w_div_trial[DATA_WIDTH-1:0];
            w_lo_nxt = {r_lo[DATA_WIDTH-2:0], ~w_div_trial[DATA_WIDTH]};
        end else begin
            w_hi_nxt = w_mul_sum[DATA_WIDTH:1];
            w_lo_nxt = {w_mul_sum[0], r_lo[DATA_WIDTH-1:1]};
        end
    end

    assign o_last   = r_active && (r_count == LAST_STEP);
    assign o_result = r_sel_lo ? w_lo_nxt : w_hi_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= 1'b0;
            r_count  <= '0;
        end else if (i_abort) begin
            r_active <= 1'b0;
            r_count  <= '0;
        end else if (i_start && !r_active) begin
            r_active <= 1'b1;
            r_count  <= '0;
        end else if (r_active) begin
            r_count <= r_count + CW'(1);
            if (o_last) begin
                r_active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_start && !r_active) begin
            r_is_div <= (i_op == OP_DIVU) || (i_op == OP_REMU);
            r_sel_lo <= (i_op == OP_MUL)  || (i_op == OP_DIVU);
            r_hi     <= '0;
            r_lo     <= ((i_op == OP_DIVU) || (i_op == OP_REMU)) ? i_a : i_b;
            r_opnd   <= ((i_op == OP_DIVU) || (i_op == OP_REMU)) ? i_b : i_a;
        end else if (r_active) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative mul/div with upstream stall, registered EX/MEM outputs.
module execute_stage
    import execute_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 6
) (
    input  logic     clk,
    input  logic     rst,
    execute_if.slave bus
);
    localparam int SHW = $clog2(DATA_WIDTH);

    state_t                       r_state;
    logic                         r_out_valid;
    logic [DATA_WIDTH-1:0]        r_result;
    logic                         r_zero;
    logic [DATA_WIDTH-1:0]        r_store;
    logic [REG_ADDR_WIDTH-1:0]    r_reg_addr;
    logic [2:0]                   r_mem;
    logic [1:0]                   r_wb;
    logic [DATA_WIDTH-1:0]        r_pend_store;
    logic [REG_ADDR_WIDTH-1:0]    r_pend_addr;
    logic [2:0]                   r_pend_mem;
    logic [1:0]                   r_pend_wb;

    logic                         w_is_multi;
    logic                         w_accept_multi;
    logic                         w_mul_last;
    logic [DATA_WIDTH-1:0]        w_mul_result;
    logic [DATA_WIDTH-1:0]        w_alu_result;
    logic signed [DATA_WIDTH-1:0] w_a_s;
    logic signed [DATA_WIDTH-1:0] w_b_s;
    logic [SHW-1:0]               w_shamt;

    assign w_is_multi     = is_multi_cycle(bus.ex_ctrl_in);
    assign w_accept_multi = (r_state == ST_IDLE) && bus.in_valid && w_is_multi && !bus.flush;
    assign w_a_s          = bus.op_a;
    assign w_b_s          = bus.op_b;
    assign w_shamt        = bus.op_b[SHW-1:0];

    always_comb begin
        w_alu_result = '0;
        case (bus.ex_ctrl_in)
            OP_ADD:   w_alu_result = bus.op_a + bus.op_b;
            OP_SUB:   w_alu_result = bus.op_a - bus.op_b;
            OP_AND:   w_alu_result = bus.op_a & bus.op_b;
            OP_OR:    w_alu_result = bus.op_a | bus.op_b;
            OP_XOR:   w_alu_result = bus.op_a ^ bus.op_b;
            OP_SLL:   w_alu_result = bus.op_a << w_shamt;
            OP_SRL:   w_alu_result = bus.op_a >> w_shamt;
            OP_SRA:   w_alu_result = w_a_s >>> w_shamt;
            OP_SLT:   w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
            OP_SLTU:  w_alu_result = {{(DATA_WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
            OP_PASSB: w_alu_result = bus.op_b;
            OP_NOP:   w_alu_result = '0;
            default:  w_alu_result = '0;
        endcase
    end

    execute_muldiv_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept_multi),
        .i_abort  (bus.flush),
        .i_op     (bus.ex_ctrl_in),
        .i_a      (bus.op_a),
        .i_b      (bus.op_b),
        .o_last   (w_mul_last),
        .o_result (w_mul_result)
    );

    // Upstream releases on the same edge the multi-cycle result registers
    assign bus.stall_out = !rst && !bus.flush &&
                           (((r_state == ST_IDLE) && bus.in_valid && w_is_multi) ||
                            ((r_state == ST_BUSY) && !w_mul_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_store     <= '0;
            r_reg_addr  <= '0;
            r_mem       <= '0;
            r_wb        <= '0;
        end else if (bus.flush) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            if (w_mul_last) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b1;
                r_result    <= w_mul_result;
                r_zero      <= (w_mul_result == '0);
                r_store     <= r_pend_store;
                r_reg_addr  <= r_pend_addr;
                r_mem       <= r_pend_mem;
                r_wb        <= r_pend_wb;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (bus.in_valid && !w_is_multi) begin
            r_out_valid <= 1'b1;
            r_result    <= w_alu_result;
            r_zero      <= (w_alu_result == '0);
            r_store     <= bus.op_b;
            r_reg_addr  <= bus.reg_addr_in;
            r_mem       <= bus.mem_ctrl_in;
            r_wb        <= bus.wb_ctrl_in;
        end else if (bus.in_valid) begin
            r_state     <= ST_BUSY;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept_multi) begin
            r_pend_store <= bus.op_b;
            r_pend_addr  <= bus.reg_addr_in;
            r_pend_mem   <= bus.mem_ctrl_in;
            r_pend_wb    <= bus.wb_ctrl_in;
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.result_out     = r_result;
    assign bus.zero_out       = r_zero;
    assign bus.store_data_out = r_store;
    assign bus.reg_addr_out   = r_reg_addr;
    assign bus.mem_ctrl_out   = r_mem;
    assign bus.wb_ctrl_out    = r_wb;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed corner cases plus randomized instruction stream.
module tb_execute_stage;
    import execute_pkg::*;

    localparam int DW = 32;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic [31:0] store;
        logic [5:0]  addr;
        logic [2:0]  mem;
        logic [1:0]  wb;
        int          edge_no;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t mon_e;

    execute_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(6)) bus ();

    execute_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model straight from the opcode definitions
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] ones;
        logic [31:0] r;
        int          sh;
        ones = 32'hFFFF_FFFF;
        sh   = int'(b[4:0]);
        p    = {32'd0, a} * {32'd0, b};
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_SLL:   r = a << sh;
            OP_SRL:   r = a >> sh;
            OP_SRA:   r = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
            OP_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:  r = (a < b) ? 32'd1 : 32'd0;
            OP_MUL:   r = p[31:0];
            OP_MULHU: r = p[63:32];
            OP_DIVU:  r = (b == 0) ? ones : a / b;
            OP_REMU:  r = (b == 0) ? a : a % b;
            OP_PASSB: r = b;
            default:  r = 32'd0;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out_valid: got out_valid=1 at edge %0d, expected no result", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result_out", bus.result_out, mon_e.result);
                check("zero_out", bus.zero_out, mon_e.zero);
                check("store_data_out", bus.store_data_out, mon_e.store);
                check("reg_addr_out", bus.reg_addr_out, mon_e.addr);
                check("mem_ctrl_out", bus.mem_ctrl_out, mon_e.mem);
                check("wb_ctrl_out", bus.wb_ctrl_out, mon_e.wb);
                check("result_edge", cyc, mon_e.edge_no);
            end
        end
    end

    // Present one instruction, hold it while stalled, and check the stall length
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        bit   st;
        bit   multi;
        multi = (op >= OP_MUL) && (op <= OP_REMU);
        @(negedge clk);
        bus.in_valid    = 1'b1;
        bus.ex_ctrl_in  = op;
        bus.op_a        = a;
        bus.op_b        = b;
        bus.reg_addr_in = 6'($urandom);
        bus.mem_ctrl_in = 3'($urandom);
        bus.wb_ctrl_in  = 2'($urandom);
        e.result  = model(op, a, b);
        e.zero    = (e.result == 32'd0);
        e.store   = b;
        e.addr    = bus.reg_addr_in;
        e.mem     = bus.mem_ctrl_in;
        e.wb      = bus.wb_ctrl_in;
        e.edge_no = cyc + 1 + (multi ? DW : 0);
        sb.push_back(e);
        n = 0;
        for (int k = 0; k < DW + 8; k++) begin
            #1;
            st = bus.stall_out;
            if (st) n++;
            @(posedge clk);
            if (!st) break;
            @(negedge clk);
        end
        check("stall_cycles", n, multi ? DW : 0);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.reg_addr_in = '0;
        bus.ex_ctrl_in  = OP_NOP;
        bus.mem_ctrl_in = '0;
        bus.wb_ctrl_in  = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        bus.in_valid   = 1'b1;
        bus.ex_ctrl_in = OP_MUL;
        #2;
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_result", bus.result_out, 32'd0);
        check("reset_stall", bus.stall_out, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);

        issue(OP_ADD,   32'hFFFF_FFFF, 32'd1);
        issue(OP_SRA,   32'h8000_0000, 32'd4);
        issue(OP_SLT,   32'hFFFF_FFFF, 32'd1);
        issue(OP_SLTU,  32'hFFFF_FFFF, 32'd1);
        issue(OP_MUL,   32'h0001_0000, 32'h0001_0000);
        issue(OP_MULHU, 32'h0001_0000, 32'h0001_0000);
        issue(OP_DIVU,  32'd100, 32'd7);
        issue(OP_REMU,  32'd100, 32'd7);
        issue(OP_DIVU,  32'd5, 32'd0);
        issue(OP_REMU,  32'd5, 32'd0);
        issue(OP_ADD,   $urandom, $urandom);
        issue(OP_MULHU, $urandom, $urandom);
        issue(OP_ADD,   $urandom, $urandom);
        idle_cycle();

        // Flush in the 10th BUSY cycle: the divide must vanish
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.ex_ctrl_in = OP_DIVU;
        bus.op_a       = 32'd1000;
        bus.op_b       = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        #1 check("stall_mid_busy", bus.stall_out, 1'b1);
        bus.flush = 1'b1;
        #1 check("stall_during_flush", bus.stall_out, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        #1 check("stall_after_flush", bus.stall_out, 1'b0);
        repeat (40) @(posedge clk);
        issue(OP_ADD, 32'd20, 32'd22);

        // Reset in the middle of a divide
        issue(OP_ADD, 32'h1234, 32'd1);
        @(negedge clk);
        bus.in_valid   = 1'b1;
        bus.ex_ctrl_in = OP_DIVU;
        bus.op_a       = 32'd77;
        bus.op_b       = 32'd5;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #2;
        check("stall_before_rst", bus.stall_out, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result_out, 32'd0);
        check("rst_zero", bus.zero_out, 1'b0);
        check("rst_store", bus.store_data_out, 32'd0);
        check("rst_reg_addr", bus.reg_addr_out, 6'd0);
        check("rst_mem_ctrl", bus.mem_ctrl_out, 3'd0);
        check("rst_wb_ctrl", bus.wb_ctrl_out, 2'd0);
        check("rst_stall", bus.stall_out, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        issue(OP_ADD, 32'd7, 32'd8);

        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick();
            b  = pick();
            issue(op, a, b);
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end
        idle_cycle();
        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
